vga_scaled_timing_gen: RTL and testbench

- Parametrised VGA timing generator with integer pixel downscaling and a latency-compensated colour path.
- Generalises the fixed 800x600@60 / 4x4-downscale top into arbitrary mode timing, scale factors, colour width and pixel-source read latency.
- Adds a built-in colour-bar test pattern.
- Sits between a pixel source (framebuffer or ROM, addressed by o_x/o_y) and the VGA pins.

---
 rtl/vga_timing_pkg.sv | 42 ++++
 rtl/vga_scaled_timing_gen_if.sv | 33 +++
 rtl/vga_delay_line.sv | 29 ++
 rtl/vga_scaled_timing_gen.sv | 161 ++++++++++++++++
 tb/tb_vga_scaled_timing_gen.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions: standard mode sets, colour-bar encoding,
// the alignment bundle carried through the latency pipe, and a width helper.
package vga_timing_pkg;

  typedef struct packed {
    int active;
    int fp;
    int sync;
    int bp;
    int pol;
  } vga_axis_t;

  typedef struct packed {
    vga_axis_t h;
    vga_axis_t v;
  } vga_mode_t;

  localparam vga_mode_t MODE_640X480_60  = '{'{640, 16, 96, 48, 0}, '{480, 10, 2, 33, 0}};
  localparam vga_mode_t MODE_800X600_60  = '{'{800, 40, 128, 88, 1}, '{600, 1, 4, 23, 1}};
  localparam vga_mode_t MODE_1024X768_60 = '{'{1024, 24, 136, 160, 0}, '{768, 3, 6, 29, 0}};

  localparam int         BAR_COUNT = 8;
  localparam logic [2:0] BAR_WHITE = 3'b111;

  // Stage-0 facts that must reach the output register together with the pixel data.
  typedef struct packed {
    logic       pat;
    logic       act;
    logic       hs;
    logic       vs;
    logic [2:0] rgb;
  } vga_align_t;

  // Ceiling log2, never below 1 so that degenerate ranges still get a real bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/vga_scaled_timing_gen_if.sv
// Pixel-source request/response bus plus the VGA pin outputs of the timing generator.
interface vga_scaled_timing_gen_if #(
  parameter int X_W     = 8,
  parameter int Y_W     = 8,
  parameter int COLOR_W = 2
);
  logic               o_req;
  logic [X_W-1:0]     o_x;
  logic [Y_W-1:0]     o_y;
  logic               o_frame_start;
  logic               o_line_start;
  logic               i_pattern_en;
  logic [COLOR_W-1:0] i_red;
  logic [COLOR_W-1:0] i_green;
  logic [COLOR_W-1:0] i_blue;
  logic [COLOR_W-1:0] o_red;
  logic [COLOR_W-1:0] o_green;
  logic [COLOR_W-1:0] o_blue;
  logic               o_hsync;
  logic               o_vsync;

  modport master (
    output o_req, o_x, o_y, o_frame_start, o_line_start,
    output o_red, o_green, o_blue, o_hsync, o_vsync,
    input  i_pattern_en, i_red, i_green, i_blue
  );

  modport slave (
    input  o_req, o_x, o_y, o_frame_start, o_line_start,
    input  o_red, o_green, o_blue, o_hsync, o_vsync,
    output i_pattern_en, i_red, i_green, i_blue
  );
endinterface

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with synchronous flush; depth 0 degenerates to a wire.
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  if (DEPTH == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign q = d;
  end else begin : g_shift
    logic [WIDTH-1:0] sr [DEPTH];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
      end else begin
        sr[0] <= d;
        for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
    end

    assign q = sr[DEPTH-1];
  end
endmodule

// File: rtl/vga_scaled_timing_gen.sv
// VGA timing generator with integer downscaled addressing, a colour-bar pattern
// and a colour/sync path delayed to match the pixel source's read latency.
module vga_scaled_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = MODE_800X600_60.h.active,
  parameter int H_FP     = MODE_800X600_60.h.fp,
  parameter int H_SYNC   = MODE_800X600_60.h.sync,
  parameter int H_BP     = MODE_800X600_60.h.bp,
  parameter int V_ACTIVE = MODE_800X600_60.v.active,
  parameter int V_FP     = MODE_800X600_60.v.fp,
  parameter int V_SYNC   = MODE_800X600_60.v.sync,
  parameter int V_BP     = MODE_800X600_60.v.bp,
  parameter int H_POL    = MODE_800X600_60.h.pol,
  parameter int V_POL    = MODE_800X600_60.v.pol,
  parameter int SCALE_X  = 4,
  parameter int SCALE_Y  = 4,
  parameter int COLOR_W  = 2,
  parameter int LATENCY  = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  vga_scaled_timing_gen_if.master bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW  = clog2(H_TOTAL);
  localparam int VW  = clog2(V_TOTAL);
  localparam int XW  = clog2(H_ACTIVE / SCALE_X);
  localparam int YW  = clog2(V_ACTIVE / SCALE_Y);
  localparam int SXW = clog2(SCALE_X);
  localparam int SYW = clog2(SCALE_Y);
  localparam logic HS_ON = (H_POL != 0);
  localparam logic VS_ON = (V_POL != 0);

  if (SCALE_X < 1 || (H_ACTIVE % SCALE_X) != 0) begin : g_bad_scale_x
    $error("SCALE_X must be >= 1 and divide H_ACTIVE");
  end
  if (SCALE_Y < 1 || (V_ACTIVE % SCALE_Y) != 0) begin : g_bad_scale_y
    $error("SCALE_Y must be >= 1 and divide V_ACTIVE");
  end

  function automatic logic [COLOR_W-1:0] bar_level(input logic on);
    return {COLOR_W{on}};
  endfunction

  logic           vld_p0;
  logic [HW-1:0]  h_cnt_p0;
  logic [VW-1:0]  v_cnt_p0;
  logic [SXW-1:0] sub_x_p0;
  logic [SYW-1:0] sub_y_p0;
  logic [XW-1:0]  x_p0;
  logic [YW-1:0]  y_p0;
  logic           h_wrap, v_wrap, h_act, v_act, req_p0;
  logic [2:0]     bar_idx_p0;
  vga_align_t     in_p0, dly_p1;

  assign h_wrap = int'(h_cnt_p0) == H_TOTAL - 1;
  assign v_wrap = int'(v_cnt_p0) == V_TOTAL - 1;
  assign h_act  = int'(h_cnt_p0) < H_ACTIVE;
  assign v_act  = int'(v_cnt_p0) < V_ACTIVE;

  // ---- stage 0: raster position; vld_p0 gives one idle clock after reset so
  // the first running clock presents h=0, v=0 rather than skipping it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_p0   <= 1'b0;
      h_cnt_p0 <= '0;
      v_cnt_p0 <= '0;
      sub_x_p0 <= '0;
      sub_y_p0 <= '0;
      x_p0     <= '0;
      y_p0     <= '0;
    end else if (!vld_p0) begin
      vld_p0 <= 1'b1;
    end else if (h_wrap) begin
      h_cnt_p0 <= '0;
      sub_x_p0 <= '0;
      x_p0     <= '0;
      if (v_wrap) begin
        v_cnt_p0 <= '0;
        sub_y_p0 <= '0;
        y_p0     <= '0;
      end else begin
        v_cnt_p0 <= v_cnt_p0 + VW'(1);
        // Stop one line early so o_y holds its last row through vertical blanking.
        if (int'(v_cnt_p0) < V_ACTIVE - 1) begin
          if (sub_y_p0 == SYW'(SCALE_Y - 1)) begin
            sub_y_p0 <= '0;
            y_p0     <= y_p0 + YW'(1);
          end else begin
            sub_y_p0 <= sub_y_p0 + SYW'(1);
          end
        end
      end
    end else begin
      h_cnt_p0 <= h_cnt_p0 + HW'(1);
      if (int'(h_cnt_p0) < H_ACTIVE - 1) begin
        if (sub_x_p0 == SXW'(SCALE_X - 1)) begin
          sub_x_p0 <= '0;
          x_p0     <= x_p0 + XW'(1);
        end else begin
          sub_x_p0 <= sub_x_p0 + SXW'(1);
        end
      end
    end
  end

  assign req_p0            = vld_p0 & h_act & v_act;
  assign bus.o_req         = req_p0;
  assign bus.o_x           = x_p0;
  assign bus.o_y           = y_p0;
  assign bus.o_frame_start = vld_p0 & (h_cnt_p0 == '0) & (v_cnt_p0 == '0);
  assign bus.o_line_start  = vld_p0 & (h_cnt_p0 == '0);

  assign bar_idx_p0 = 3'((int'(x_p0) * SCALE_X * BAR_COUNT) / H_ACTIVE);

  assign in_p0.pat = bus.i_pattern_en;
  assign in_p0.act = req_p0;
  assign in_p0.hs  = (int'(h_cnt_p0) >= H_ACTIVE + H_FP) && (int'(h_cnt_p0) < H_ACTIVE + H_FP + H_SYNC);
  assign in_p0.vs  = (int'(v_cnt_p0) >= V_ACTIVE + V_FP) && (int'(v_cnt_p0) < V_ACTIVE + V_FP + V_SYNC);
  assign in_p0.rgb = BAR_WHITE - bar_idx_p0;

  // ---- stage 1..LATENCY: wait for the pixel source's read data
  vga_delay_line #(
    .WIDTH($bits(vga_align_t)),
    .DEPTH(LATENCY)
  ) u_align (
    .clk(i_clk),
    .rst(i_rst),
    .d  (in_p0),
    .q  (dly_p1)
  );

  // ---- output register: combine delayed timing with source data or bars
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bus.o_red   <= '0;
      bus.o_green <= '0;
      bus.o_blue  <= '0;
      bus.o_hsync <= ~HS_ON;
      bus.o_vsync <= ~VS_ON;
    end else begin
      bus.o_hsync <= dly_p1.hs ? HS_ON : ~HS_ON;
      bus.o_vsync <= dly_p1.vs ? VS_ON : ~VS_ON;
      if (!dly_p1.act) begin
        bus.o_red   <= '0;
        bus.o_green <= '0;
        bus.o_blue  <= '0;
      end else if (dly_p1.pat) begin
        bus.o_red   <= bar_level(dly_p1.rgb[2]);
        bus.o_green <= bar_level(dly_p1.rgb[1]);
        bus.o_blue  <= bar_level(dly_p1.rgb[0]);
      end else begin
        bus.o_red   <= bus.i_red;
        bus.o_green <= bus.i_green;
        bus.o_blue  <= bus.i_blue;
      end
    end
  end
endmodule

// File: tb/tb_vga_scaled_timing_gen.sv
// Scoreboard bench: a small-mode instance under random inputs and resets, and a
// default 800x600 instance in pattern mode, both against a raster-position model.
module tb_vga_scaled_timing_gen;
  import vga_timing_pkg::*;

  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int SX = 2, SY = 2, LAT = 2, CW = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int XW = clog2(HA / SX);
  localparam int YW = clog2(VA / SY);
  localparam int NCYC = 2300;
  localparam int BIG_HT = 1056;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic rst_big = 1'b1;

  vga_scaled_timing_gen_if #(.X_W(XW), .Y_W(YW), .COLOR_W(CW)) bus ();
  vga_scaled_timing_gen_if #(.X_W(clog2(200)), .Y_W(clog2(150)), .COLOR_W(2)) bus_big ();

  vga_scaled_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(1), .V_POL(1), .SCALE_X(SX), .SCALE_Y(SY),
    .COLOR_W(CW), .LATENCY(LAT)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  vga_scaled_timing_gen dut_big (
    .i_clk(clk),
    .i_rst(rst_big),
    .bus  (bus_big)
  );

  typedef struct {
    int cyc;
    logic req; logic [XW-1:0] x; logic [YW-1:0] y; logic fs, ls;
    logic [1:0] r, g, b; logic hs, vs;
  } exp_t;

  typedef struct {
    int cyc;
    logic [1:0] r, g, b; logic hs, vs;
  } exp_big_t;

  typedef struct packed {
    logic act; logic hs; logic vs; logic [2:0] rgb;
  } rec_t;

  exp_t     q_s[$];
  exp_big_t q_b[$];
  int checks = 0;
  int errors = 0;

  logic          rst_drv  [NCYC];
  logic          pat_drv  [NCYC];
  logic [1:0]    red_drv  [NCYC];
  logic [1:0]    g_drv    [NCYC];
  logic [1:0]    b_drv    [NCYC];
  logic          seen_req [NCYC];
  logic [XW-1:0] seen_x   [NCYC];
  rec_t          rec      [NCYC];

  function automatic logic get_rst(input int i);
    if (i < 0) return 1'b1;
    return rst_drv[i];
  endfunction

  function automatic logic [1:0] lvl(input logic on);
    return on ? 2'b11 : 2'b00;
  endfunction

  task automatic chk(input string name, input int cyc, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: pops one expected record per DUT per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    exp_big_t eb;
    forever begin
      @(negedge clk);
      if (q_s.size() > 0) begin
        e = q_s.pop_front();
        chk("req",         e.cyc, int'(bus.o_req),         int'(e.req));
        chk("x",           e.cyc, int'(bus.o_x),           int'(e.x));
        chk("y",           e.cyc, int'(bus.o_y),           int'(e.y));
        chk("frame_start", e.cyc, int'(bus.o_frame_start), int'(e.fs));
        chk("line_start",  e.cyc, int'(bus.o_line_start),  int'(e.ls));
        chk("red",         e.cyc, int'(bus.o_red),         int'(e.r));
        chk("green",       e.cyc, int'(bus.o_green),       int'(e.g));
        chk("blue",        e.cyc, int'(bus.o_blue),        int'(e.b));
        chk("hsync",       e.cyc, int'(bus.o_hsync),       int'(e.hs));
        chk("vsync",       e.cyc, int'(bus.o_vsync),       int'(e.vs));
      end
      if (q_b.size() > 0) begin
        eb = q_b.pop_front();
        chk("big_red",   eb.cyc, int'(bus_big.o_red),   int'(eb.r));
        chk("big_green", eb.cyc, int'(bus_big.o_green), int'(eb.g));
        chk("big_blue",  eb.cyc, int'(bus_big.o_blue),  int'(eb.b));
        chk("big_hsync", eb.cyc, int'(bus_big.o_hsync), int'(eb.hs));
        chk("big_vsync", eb.cyc, int'(bus_big.o_vsync), int'(eb.vs));
      end
    end
  end

  // Stimulus and reference model.
  initial begin
    int mr1, len1, mr2;
    int next_pos, pos, h, v, xi, yi, p;
    logic valid;
    rec_t rr;
    exp_t e;
    exp_big_t eb;
    logic [2:0] rgb;

    bus.i_pattern_en     = 1'b0;
    bus.i_red            = '0;
    bus.i_green          = '0;
    bus.i_blue           = '0;
    bus_big.i_pattern_en = 1'b1;
    bus_big.i_red        = 2'b11;
    bus_big.i_green      = 2'b11;
    bus_big.i_blue       = 2'b11;
    mr1  = 1200 + int'($urandom_range(0, 97));
    len1 = int'($urandom_range(1, 3));
    mr2  = 1700 + int'($urandom_range(0, 97));
    next_pos = 0;
    pos = 0;

    for (int k = 0; k < NCYC; k++) begin
      @(posedge clk);
      #1;
      seen_req[k] = bus.o_req;
      seen_x[k]   = bus.o_x;

      rst_drv[k] = (k < 3) || (k >= mr1 && k < mr1 + len1) || (k == mr2);
      if (k < 400)      pat_drv[k] = 1'b0;
      else if (k < 700) pat_drv[k] = 1'b1;
      else              pat_drv[k] = 1'($urandom_range(0, 1));
      // Modelled pixel source: returns o_x two clocks later, junk outside requests.
      red_drv[k] = (k >= 2 && seen_req[k-2]) ? seen_x[k-2] : 2'b11;
      g_drv[k]   = 2'($urandom);
      b_drv[k]   = 2'($urandom);

      rst              = rst_drv[k];
      rst_big          = (k < 3);
      bus.i_pattern_en = pat_drv[k];
      bus.i_red        = red_drv[k];
      bus.i_green      = g_drv[k];
      bus.i_blue       = b_drv[k];

      e = '{default: '0};
      e.cyc = k;
      if (get_rst(k - 1)) begin
        valid = 1'b0;
        next_pos = 0;
      end else begin
        valid = 1'b1;
        pos = next_pos;
        next_pos = (pos + 1) % FT;
      end
      rec[k] = '0;
      if (valid) begin
        h  = pos % HT;
        v  = pos / HT;
        xi = ((h < HA) ? h : HA - 1) / SX;
        yi = ((v < VA) ? v : VA - 1) / SY;
        e.req = (h < HA) && (v < VA);
        e.x   = XW'(xi);
        e.y   = YW'(yi);
        e.fs  = (pos == 0);
        e.ls  = (h == 0);
        rec[k].act = e.req;
        rec[k].hs  = (h >= HA + HF) && (h < HA + HF + HS);
        rec[k].vs  = (v >= VA + VF) && (v < VA + VF + VS);
        rec[k].rgb = 3'(7 - (xi * SX * 8) / HA);
      end

      if (!(get_rst(k - 1) || get_rst(k - 2) || get_rst(k - 3))) begin
        rr   = rec[k-3];
        e.hs = rr.hs;
        e.vs = rr.vs;
        if (rr.act) begin
          if (pat_drv[k-3]) begin
            e.r = lvl(rr.rgb[2]);
            e.g = lvl(rr.rgb[1]);
            e.b = lvl(rr.rgb[0]);
          end else begin
            e.r = red_drv[k-1];
            e.g = g_drv[k-1];
            e.b = b_drv[k-1];
          end
        end
      end
      q_s.push_back(e);

      // Default mode in pattern mode: bars are 100 pixels wide, white first.
      eb = '{default: '0};
      eb.cyc = k;
      if (k >= 7) begin
        p = k - 7;
        h = p % BIG_HT;
        v = p / BIG_HT;
        if (h < 800 && v < 600) begin
          rgb  = 3'(7 - h / 100);
          eb.r = lvl(rgb[2]);
          eb.g = lvl(rgb[1]);
          eb.b = lvl(rgb[0]);
        end
        eb.hs = (h >= 840) && (h < 968);
        eb.vs = (v >= 601) && (v < 605);
      end
      q_b.push_back(eb);
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
